mini_src_control_unit: RTL and testbench

- Hardwired Moore control sequencer for the Mini SRC datapath; sits directly upstream of the CPU datapath.
- Replaces the bench-driven T0..Tn strobes with an FSM. It decodes IR[31:27] and conCFF, and drives every bus-source, register-load and memory strobe.
- Fetch is T0-T2; the execute steps (T3..T7) are chosen by opcode.

---
 rtl/mini_src_control_unit_if.sv | 23 ++
 rtl/mini_src_control_unit.sv | 163 ++++++++++++++++
 tb/tb_mini_src_control_unit.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mini_src_control_unit_if.sv
// Strobe bundle between the Mini SRC control sequencer (master) and the datapath (slave).
interface mini_src_control_unit_if;
    logic [31:0] ir;
    logic        con_ff;
    logic        stop;
    logic [9:0]  drive_sel;
    logic [11:0] load_en;
    logic [2:0]  gr;
    logic        IncPC;
    logic        Read;
    logic        Write;
    logic        run;

    modport master (
        input  ir, con_ff, stop,
        output drive_sel, load_en, gr, IncPC, Read, Write, run
    );

    modport slave (
        output ir, con_ff, stop,
        input  drive_sel, load_en, gr, IncPC, Read, Write, run
    );
endinterface

// File: rtl/mini_src_control_unit.sv
// Mini SRC hardwired Moore sequencer; CTRL_ILLEGAL_HALT_EN makes jal/11011-11111 halt after fetch.
// Outputs decode combinationally from state+opcode; memory steps stretch by MEM_WAIT cycles, no other stall.
module mini_src_control_unit #(
    parameter int MEM_WAIT = 0
) (
    input logic clk,
    input logic clr,
    mini_src_control_unit_if.master ctl
);
    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    localparam int D_PC = 9, D_ZHI = 8, D_ZLO = 7, D_MDR = 6, D_HI = 5;
    localparam int D_LO = 4, D_IN = 3, D_C = 2, D_R = 1, D_BA = 0;
    localparam int L_PC = 11, L_IR = 10, L_MAR = 9, L_MDR = 8, L_Y = 7, L_ZHI = 6;
    localparam int L_ZLO = 5, L_HI = 4, L_LO = 3, L_R = 2, L_CON = 1, L_OUT = 0;
    localparam int G_A = 2, G_B = 1, G_C = 0;
    localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);
`ifdef CTRL_ILLEGAL_HALT_EN
    localparam bit ILL_HALT = 1'b1;
`else
    localparam bit ILL_HALT = 1'b0;
`endif

    state_t      state, state_nxt;
    logic [2:0]  wait_cnt;
    logic [4:0]  op;
    logic        op_alu, op_imm, op_md, op_neg, op_ldi, op_ld, op_st, op_brx;
    logic        op_jr, op_in, op_out, op_mfhi, op_mflo, op_halt, op_ill, op_exec;
    logic        hold, wait_done, first_beat, last_step;
    logic [9:0]  ds;
    logic [11:0] le;
    logic [2:0]  grs;
    logic        inc_pc, rd, wr;
    logic        unused_ir;

    assign op        = ctl.ir[31:27];
    assign unused_ir = ^ctl.ir[26:0];
    assign op_alu    = (op >= 5'd3) && (op <= 5'd10);
    assign op_imm    = (op >= 5'd11) && (op <= 5'd13);
    assign op_md     = (op == 5'd14) || (op == 5'd15);
    assign op_neg    = (op == 5'd16) || (op == 5'd17);
    assign op_ld     = (op == 5'd0);
    assign op_ldi    = (op == 5'd1);
    assign op_st     = (op == 5'd2);
    assign op_brx    = (op == 5'd18);
    assign op_jr     = (op == 5'd19);
    assign op_in     = (op == 5'd21);
    assign op_out    = (op == 5'd22);
    assign op_mfhi   = (op == 5'd23);
    assign op_mflo   = (op == 5'd24);
    assign op_halt   = (op == 5'd26);
    assign op_ill    = (op == 5'd20) || (op >= 5'd27);
    assign op_exec   = op_alu | op_imm | op_md | op_neg | op_ld | op_ldi | op_st | op_brx
                     | op_jr | op_in | op_out | op_mfhi | op_mflo;

    // Memory steps share one counter; it is zero on entry so beat 0 is recognisable.
    assign hold       = (state == S_T1) || ((state == S_T6) && op_ld) || ((state == S_T7) && op_st);
    assign wait_done  = (wait_cnt == WAIT_LAST);
    assign first_beat = (wait_cnt == 3'd0);

    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= S_RST;
            wait_cnt <= 3'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= (hold && !wait_done) ? wait_cnt + 3'd1 : 3'd0;
        end
    end

    always_comb begin
        state_nxt = state;
        last_step = 1'b0;
        case (state)
            S_RST: state_nxt = S_T0;
            S_T0:  state_nxt = S_T1;
            S_T1:  if (wait_done) state_nxt = S_T2;
            S_T2: begin
                if (op_halt || (ILL_HALT && op_ill)) state_nxt = S_HALT;
                else if (op_exec)                   state_nxt = S_T3;
                else                                last_step = 1'b1;
            end
            S_T3: if (op_jr | op_in | op_out | op_mfhi | op_mflo) last_step = 1'b1;
                  else state_nxt = S_T4;
            S_T4: if (op_neg) last_step = 1'b1;
                  else state_nxt = S_T5;
            S_T5: if (op_alu | op_imm | op_ldi) last_step = 1'b1;
                  else state_nxt = S_T6;
            S_T6: begin
                if (op_ld)      begin if (wait_done) state_nxt = S_T7; end
                else if (op_st) state_nxt = S_T7;
                else            last_step = 1'b1;
            end
            S_T7: if (!op_st || wait_done) last_step = 1'b1;
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_RST;
        endcase
        if (last_step) state_nxt = ctl.stop ? S_HALT : S_T0;
    end

    always_comb begin
        ds     = '0;
        le     = '0;
        grs    = '0;
        inc_pc = 1'b0;
        rd     = 1'b0;
        wr     = 1'b0;
        case (state)
            S_T0: begin ds[D_PC] = 1'b1; le[L_MAR] = 1'b1; le[L_ZLO] = 1'b1; inc_pc = 1'b1; end
            S_T1: begin
                if (first_beat) begin ds[D_ZLO] = 1'b1; le[L_PC] = 1'b1; end
                rd = 1'b1; le[L_MDR] = 1'b1;
            end
            S_T2: begin ds[D_MDR] = 1'b1; le[L_IR] = 1'b1; end
            S_T3: begin
                if (op_alu | op_imm)              begin grs[G_B] = 1'b1; ds[D_R] = 1'b1; le[L_Y] = 1'b1; end
                else if (op_md)                   begin grs[G_A] = 1'b1; ds[D_R] = 1'b1; le[L_Y] = 1'b1; end
                else if (op_neg)                  begin grs[G_B] = 1'b1; ds[D_R] = 1'b1; le[L_ZLO] = 1'b1; end
                else if (op_ldi | op_ld | op_st)  begin grs[G_B] = 1'b1; ds[D_BA] = 1'b1; le[L_Y] = 1'b1; end
                else if (op_brx)                  begin grs[G_A] = 1'b1; ds[D_R] = 1'b1; le[L_CON] = 1'b1; end
                else if (op_jr)                   begin grs[G_A] = 1'b1; ds[D_R] = 1'b1; le[L_PC] = 1'b1; end
                else if (op_in)                   begin grs[G_A] = 1'b1; ds[D_IN] = 1'b1; le[L_R] = 1'b1; end
                else if (op_out)                  begin grs[G_A] = 1'b1; ds[D_R] = 1'b1; le[L_OUT] = 1'b1; end
                else if (op_mfhi)                 begin grs[G_A] = 1'b1; ds[D_HI] = 1'b1; le[L_R] = 1'b1; end
                else if (op_mflo)                 begin grs[G_A] = 1'b1; ds[D_LO] = 1'b1; le[L_R] = 1'b1; end
            end
            S_T4: begin
                if (op_alu)                               begin grs[G_C] = 1'b1; ds[D_R] = 1'b1; le[L_ZLO] = 1'b1; end
                else if (op_imm | op_ldi | op_ld | op_st) begin ds[D_C] = 1'b1; le[L_ZLO] = 1'b1; end
                else if (op_md)  begin grs[G_B] = 1'b1; ds[D_R] = 1'b1; le[L_ZHI] = 1'b1; le[L_ZLO] = 1'b1; end
                else if (op_neg) begin grs[G_A] = 1'b1; ds[D_ZLO] = 1'b1; le[L_R] = 1'b1; end
                else if (op_brx) begin ds[D_PC] = 1'b1; le[L_Y] = 1'b1; end
            end
            S_T5: begin
                if (op_alu | op_imm | op_ldi) begin grs[G_A] = 1'b1; ds[D_ZLO] = 1'b1; le[L_R] = 1'b1; end
                else if (op_md)               begin ds[D_ZLO] = 1'b1; le[L_LO] = 1'b1; end
                else if (op_ld | op_st)       begin ds[D_ZLO] = 1'b1; le[L_MAR] = 1'b1; end
                else if (op_brx)              begin ds[D_C] = 1'b1; le[L_ZLO] = 1'b1; end
            end
            S_T6: begin
                if (op_md)       begin ds[D_ZHI] = 1'b1; le[L_HI] = 1'b1; end
                else if (op_ld)  begin rd = 1'b1; le[L_MDR] = 1'b1; end
                else if (op_st)  begin grs[G_A] = 1'b1; ds[D_R] = 1'b1; le[L_MDR] = 1'b1; end
                else if (op_brx) begin ds[D_ZLO] = 1'b1; le[L_PC] = ctl.con_ff; end
            end
            S_T7: begin
                if (op_ld)      begin grs[G_A] = 1'b1; ds[D_MDR] = 1'b1; le[L_R] = 1'b1; end
                else if (op_st) wr = 1'b1;
            end
            default: ;
        endcase
    end

    assign ctl.drive_sel = ds;
    assign ctl.load_en   = le;
    assign ctl.gr        = grs;
    assign ctl.IncPC     = inc_pc;
    assign ctl.Read      = rd;
    assign ctl.Write     = wr;
    assign ctl.run       = (state != S_RST) && (state != S_HALT);
endmodule

// File: tb/tb_mini_src_control_unit.sv
// Scoreboard bench: two sequencers (MEM_WAIT 0 and 2) run identical segments against a microprogram model.
module tb_mini_src_control_unit;
    typedef logic [28:0] vec_t;  // {run, drive_sel, load_en, gr, IncPC, Read, Write}

    localparam logic [9:0]  PCOUT = 10'h200, ZHO = 10'h100, ZLO = 10'h080, MDRO = 10'h040, HIO = 10'h020;
    localparam logic [9:0]  LOO = 10'h010, INO = 10'h008, CO = 10'h004, RO = 10'h002, BAO = 10'h001, NOD = 10'h000;
    localparam logic [11:0] PCIN = 12'h800, IRIN = 12'h400, MARIN = 12'h200, MDRIN = 12'h100, YIN = 12'h080;
    localparam logic [11:0] ZHIN = 12'h040, ZLIN = 12'h020, HIIN = 12'h010, LOIN = 12'h008, RIN = 12'h004;
    localparam logic [11:0] CONIN = 12'h002, OUTIN = 12'h001, NOL = 12'h000;
    localparam logic [2:0]  GA = 3'b100, GB = 3'b010, GC = 3'b001, G0 = 3'b000;

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    mini_src_control_unit_if i0();
    mini_src_control_unit_if i1();

    mini_src_control_unit #(.MEM_WAIT(0)) dut0 (.clk(clk), .clr(clr), .ctl(i0));
    mini_src_control_unit #(.MEM_WAIT(2)) dut1 (.clk(clk), .clr(clr), .ctl(i1));

    vec_t out0, out1;
    assign out0 = {i0.run, i0.drive_sel, i0.load_en, i0.gr, i0.IncPC, i0.Read, i0.Write};
    assign out1 = {i1.run, i1.drive_sel, i1.load_en, i1.gr, i1.IncPC, i1.Read, i1.Write};

    vec_t exp0[$], exp1[$], steps[$];
    bit   halt_end;
    int   tests = 0, fails = 0, cyc = 0;

    function automatic vec_t mk(input logic [9:0] d, input logic [11:0] l, input logic [2:0] g,
                                input bit inc = 1'b0, input bit rd = 1'b0, input bit wr = 1'b0);
        return {1'b1, d, l, g, inc, rd, wr};
    endfunction

    // One instruction as a list of step vectors, written straight from the microcode table.
    task automatic build(input logic [4:0] op, input bit con, input int mw);
        steps.delete();
        halt_end = (op == 5'd26);
`ifdef CTRL_ILLEGAL_HALT_EN
        if (op == 5'd20 || op >= 5'd27) halt_end = 1'b1;
`endif
        steps.push_back(mk(PCOUT, MARIN | ZLIN, G0, 1'b1));
        for (int i = 0; i <= mw; i++)
            steps.push_back(mk((i == 0) ? ZLO : NOD, ((i == 0) ? PCIN : NOL) | MDRIN, G0, 1'b0, 1'b1));
        steps.push_back(mk(MDRO, IRIN, G0));
        case (op) inside
            [5'd3:5'd10]: begin
                steps.push_back(mk(RO, YIN, GB)); steps.push_back(mk(RO, ZLIN, GC)); steps.push_back(mk(ZLO, RIN, GA));
            end
            [5'd11:5'd13], 5'd1: begin
                steps.push_back(mk((op == 5'd1) ? BAO : RO, YIN, GB));
                steps.push_back(mk(CO, ZLIN, G0)); steps.push_back(mk(ZLO, RIN, GA));
            end
            5'd14, 5'd15: begin
                steps.push_back(mk(RO, YIN, GA)); steps.push_back(mk(RO, ZHIN | ZLIN, GB));
                steps.push_back(mk(ZLO, LOIN, G0)); steps.push_back(mk(ZHO, HIIN, G0));
            end
            5'd16, 5'd17: begin
                steps.push_back(mk(RO, ZLIN, GB)); steps.push_back(mk(ZLO, RIN, GA));
            end
            5'd0, 5'd2: begin
                steps.push_back(mk(BAO, YIN, GB)); steps.push_back(mk(CO, ZLIN, G0)); steps.push_back(mk(ZLO, MARIN, G0));
                if (op == 5'd0) begin
                    for (int i = 0; i <= mw; i++) steps.push_back(mk(NOD, MDRIN, G0, 1'b0, 1'b1));
                    steps.push_back(mk(MDRO, RIN, GA));
                end else begin
                    steps.push_back(mk(RO, MDRIN, GA));
                    for (int i = 0; i <= mw; i++) steps.push_back(mk(NOD, NOL, G0, 1'b0, 1'b0, 1'b1));
                end
            end
            5'd18: begin
                steps.push_back(mk(RO, CONIN, GA)); steps.push_back(mk(PCOUT, YIN, G0));
                steps.push_back(mk(CO, ZLIN, G0)); steps.push_back(mk(ZLO, con ? PCIN : NOL, G0));
            end
            5'd19: steps.push_back(mk(RO, PCIN, GA));
            5'd21: steps.push_back(mk(INO, RIN, GA));
            5'd22: steps.push_back(mk(RO, OUTIN, GA));
            5'd23: steps.push_back(mk(HIO, RIN, GA));
            5'd24: steps.push_back(mk(LOO, RIN, GA));
            default: ;
        endcase
    endtask

    // Expected trace for a segment: RST, then the instruction repeated until halt/stop or the segment ends.
    task automatic model(input int mw, input logic [31:0] ir_v, input bit con, input bit stp, input int len);
        vec_t tr[$];
        int   k;
        bit   halted;
        build(ir_v[31:27], con, mw);
        tr.push_back('0);
        k = 0;
        halted = 1'b0;
        while (tr.size() < len) begin
            if (halted) tr.push_back('0);
            else begin
                tr.push_back(steps[k]);
                k++;
                if (k == int'(steps.size())) begin
                    k = 0;
                    halted = halt_end || stp;
                end
            end
        end
        foreach (tr[i]) begin
            if (mw == 0) exp0.push_back(tr[i]);
            else         exp1.push_back(tr[i]);
        end
    endtask

    task automatic check(input string nm, input vec_t got, input vec_t want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, got, want);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (exp0.size() > 0) check("trace_mw0", out0, exp0.pop_front());
        if (exp1.size() > 0) check("trace_mw2", out1, exp1.pop_front());
    end

    // Entered just after a rising edge; clr is taken at the next edge, inputs change after it.
    task automatic seg(input logic [31:0] ir_v, input bit con, input bit stp, input int len);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        i0.ir = ir_v;  i1.ir = ir_v;
        i0.con_ff = con; i1.con_ff = con;
        i0.stop = stp; i1.stop = stp;
        model(0, ir_v, con, stp, len);
        model(2, ir_v, con, stp, len);
        repeat (len - 1) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] r;
        bit          rc, rs;
        int          rl;
        i0.ir = '0; i1.ir = '0;
        i0.con_ff = 1'b0; i1.con_ff = 1'b0;
        i0.stop = 1'b0; i1.stop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        seg(32'h59080002, 1'b0, 1'b0, 13);   // addi twice back to back
        seg(32'h00900065, 1'b0, 1'b0, 26);   // ld r1,0x65(r2)
        seg(32'h90000000, 1'b0, 1'b0, 16);   // brx, not taken
        seg(32'h90000000, 1'b1, 1'b0, 16);   // brx, taken
        seg(32'hD0000000, 1'b0, 1'b0, 25);   // halt
        seg(32'h10800000, 1'b0, 1'b0, 8);    // st aborted by clr in T6 (MEM_WAIT=0)
        seg(32'h18000000, 1'b0, 1'b1, 14);   // add with stop
        seg(32'hF8000000, 1'b0, 1'b0, 10);   // opcode 11111
        seg(32'hA0000000, 1'b0, 1'b0, 10);   // jal
        seg(32'h70000000, 1'b0, 1'b0, 16);   // mul
        seg(32'hC8000000, 1'b0, 1'b1, 8);    // nop with stop
        for (int n = 0; n < 60; n++) begin
            r  = $urandom();
            rc = ($urandom_range(0, 1) == 1);
            rs = ($urandom_range(0, 3) == 0);
            rl = $urandom_range(1, 40);
            seg(r, rc, rs, rl);
        end
        clr = 1'b1;
        @(negedge clk);
        #1;
        tests++;
        if (exp0.size() != 0 || exp1.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d/%0d entries left, expected 0/0", exp0.size(), exp1.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
